// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer on the output side.
// Optional macro IMM_GEN_CSR_ZIMM_EN: CSR immediate forms decode as fmt Z (zimm).
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int FMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_imm,
  output logic [FMT_W-1:0] out_fmt,
  output logic [XLEN-1:0]  out_target
);

  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [FMT_W-1:0] FMT_NONE = FMT_W'(0);
  localparam logic [FMT_W-1:0] FMT_I    = FMT_W'(1);
  localparam logic [FMT_W-1:0] FMT_S    = FMT_W'(2);
  localparam logic [FMT_W-1:0] FMT_B    = FMT_W'(3);
  localparam logic [FMT_W-1:0] FMT_U    = FMT_W'(4);
  localparam logic [FMT_W-1:0] FMT_J    = FMT_W'(5);
`ifdef IMM_GEN_CSR_ZIMM_EN
  localparam logic [FMT_W-1:0] FMT_Z    = FMT_W'(6);
`endif

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  // Fields are packed at the MSB end and arithmetic-shifted down, which
  // sign-extends to any XLEN without zero-width replications.
  function automatic logic signed [XLEN-1:0] sx(input logic [XLEN-1:0] v, input int sh);
    return $signed(v) >>> sh;
  endfunction

  function automatic logic signed [XLEN-1:0] imm_i(input logic [31:0] ins);
    return sx({ins[31:20], {(XLEN-12){1'b0}}}, XLEN-12);
  endfunction

  function automatic logic signed [XLEN-1:0] imm_s(input logic [31:0] ins);
    return sx({ins[31:25], ins[11:7], {(XLEN-12){1'b0}}}, XLEN-12);
  endfunction

  function automatic logic signed [XLEN-1:0] imm_b(input logic [31:0] ins);
    return sx({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, {(XLEN-13){1'b0}}}, XLEN-13);
  endfunction

  function automatic logic signed [XLEN-1:0] imm_u(input logic [31:0] ins);
    return sx({ins[31:12], {(XLEN-20){1'b0}}}, XLEN-32);
  endfunction

  function automatic logic signed [XLEN-1:0] imm_j(input logic [31:0] ins);
    return sx({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, {(XLEN-21){1'b0}}}, XLEN-21);
  endfunction

  state_t                  state_q, state_d;
  logic                    accept, ld_out, ld_skid, mv_skid, vld_p1;

  logic signed [XLEN-1:0]  imm_p0;
  logic [FMT_W-1:0]        fmt_p0;
  logic [XLEN-1:0]         target_p0;

  logic [31:0]             out_instr_p1, skid_instr_p1;
  logic [XLEN-1:0]         out_pc_p1, skid_pc_p1;
  logic signed [XLEN-1:0]  out_imm_p1, skid_imm_p1;
  logic [FMT_W-1:0]        out_fmt_p1, skid_fmt_p1;
  logic [XLEN-1:0]         out_target_p1, skid_target_p1;

  // Stage p0: combinational decode of the incoming instruction
  always_comb begin
    fmt_p0 = FMT_NONE;
    imm_p0 = '0;
    case (in_instr[6:0])
      OP_ALUI, OP_LOAD, OP_JALR: begin
        fmt_p0 = FMT_I;
        imm_p0 = imm_i(in_instr);
      end
      OP_SYSTEM: begin
`ifdef IMM_GEN_CSR_ZIMM_EN
        if (in_instr[14]) begin
          fmt_p0 = FMT_Z;
          imm_p0 = $signed({{(XLEN-5){1'b0}}, in_instr[19:15]});
        end else begin
          fmt_p0 = FMT_I;
          imm_p0 = imm_i(in_instr);
        end
`else
        fmt_p0 = FMT_I;
        imm_p0 = imm_i(in_instr);
`endif
      end
      OP_STORE: begin
        fmt_p0 = FMT_S;
        imm_p0 = imm_s(in_instr);
      end
      OP_BRANCH: begin
        fmt_p0 = FMT_B;
        imm_p0 = imm_b(in_instr);
      end
      OP_LUI, OP_AUIPC: begin
        fmt_p0 = FMT_U;
        imm_p0 = imm_u(in_instr);
      end
      OP_JAL: begin
        fmt_p0 = FMT_J;
        imm_p0 = imm_j(in_instr);
      end
      default: begin
        fmt_p0 = FMT_NONE;
        imm_p0 = '0;
      end
    endcase
  end

  assign target_p0 = in_pc + $unsigned(imm_p0);

  // in_ready depends only on rst and the state register, never on out_ready
  assign in_ready = ~rst & (state_q != S_TWO);
  assign accept   = in_valid & in_ready & ~flush;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ld_out  = 1'b0;
    ld_skid = 1'b0;
    mv_skid = 1'b0;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d = S_ONE;
            ld_out  = 1'b1;
          end
        end
        S_ONE: begin
          if (accept && out_ready) begin
            ld_out = 1'b1;
          end else if (accept) begin
            state_d = S_TWO;
            ld_skid = 1'b1;
          end else if (out_ready) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (out_ready) begin
            state_d = S_ONE;
            mv_skid = 1'b1;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Stage p1: output register and skid register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_instr_p1  <= '0;
      out_pc_p1     <= '0;
      out_imm_p1    <= '0;
      out_fmt_p1    <= '0;
      out_target_p1 <= '0;
    end else if (ld_out) begin
      out_instr_p1  <= in_instr;
      out_pc_p1     <= in_pc;
      out_imm_p1    <= imm_p0;
      out_fmt_p1    <= fmt_p0;
      out_target_p1 <= target_p0;
    end else if (mv_skid) begin
      out_instr_p1  <= skid_instr_p1;
      out_pc_p1     <= skid_pc_p1;
      out_imm_p1    <= skid_imm_p1;
      out_fmt_p1    <= skid_fmt_p1;
      out_target_p1 <= skid_target_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_instr_p1  <= '0;
      skid_pc_p1     <= '0;
      skid_imm_p1    <= '0;
      skid_fmt_p1    <= '0;
      skid_target_p1 <= '0;
    end else if (ld_skid) begin
      skid_instr_p1  <= in_instr;
      skid_pc_p1     <= in_pc;
      skid_imm_p1    <= imm_p0;
      skid_fmt_p1    <= fmt_p0;
      skid_target_p1 <= target_p0;
    end
  end

  assign vld_p1     = (state_q != S_EMPTY);
  assign out_valid  = vld_p1;
  assign out_instr  = out_instr_p1;
  assign out_pc     = out_pc_p1;
  assign out_imm    = out_imm_p1;
  assign out_fmt    = out_fmt_p1;
  assign out_target = out_target_p1;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode vector table plus backpressure, flush
// and mid-operation reset sequences.
module tb_imm_gen_pipe;
  localparam int XLEN  = 32;
  localparam int FMT_W = 3;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]      in_instr, out_instr;
  logic [XLEN-1:0]  in_pc, out_pc, out_imm, out_target;
  logic [FMT_W-1:0] out_fmt;

  int checks = 0;
  int errors = 0;

  imm_gen_pipe #(.XLEN(XLEN), .FMT_W(FMT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_imm(out_imm), .out_fmt(out_fmt), .out_target(out_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      instr;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic [FMT_W-1:0] fmt;
    logic [XLEN-1:0]  target;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [XLEN-1:0] pc);
    in_valid = v;
    in_instr = ins;
    in_pc    = pc;
  endtask

  task automatic chk_out(input string name, input logic [31:0] ins, input logic [XLEN-1:0] pc);
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_instr"}, 64'(out_instr), 64'(ins));
    chk({name, "_pc"}, 64'(out_pc), 64'(pc));
  endtask

  initial begin
    vecs[0]  = '{32'hFFF00093, 32'h0,    32'hFFFFFFFF, 3'd1, 32'hFFFFFFFF};
    vecs[1]  = '{32'h0020A423, 32'h200,  32'h8,        3'd2, 32'h208};
    vecs[2]  = '{32'hFE000EE3, 32'h100,  32'hFFFFFFFC, 3'd3, 32'hFC};
    vecs[3]  = '{32'h123452B7, 32'h40,   32'h12345000, 3'd4, 32'h12345040};
    vecs[4]  = '{32'h0010006F, 32'h1000, 32'h800,      3'd5, 32'h1800};
`ifdef IMM_GEN_CSR_ZIMM_EN
    vecs[5]  = '{32'h300FD073, 32'h10,   32'h1F,       3'd6, 32'h2F};
`else
    vecs[5]  = '{32'h300FD073, 32'h10,   32'h300,      3'd1, 32'h310};
`endif
    vecs[6]  = '{32'h00001017, 32'h20,   32'h1000,     3'd4, 32'h1020};
    vecs[7]  = '{32'h80002083, 32'h1000, 32'hFFFFF800, 3'd1, 32'h800};
    vecs[8]  = '{32'h00008067, 32'h44,   32'h0,        3'd1, 32'h44};
    vecs[9]  = '{32'h00000033, 32'h50,   32'h0,        3'd0, 32'h50};
    vecs[10] = '{32'h30001073, 32'h0,    32'h300,      3'd1, 32'h300};
    vecs[11] = '{32'hFFDFF06F, 32'h8,    32'hFFFFFFFC, 3'd5, 32'h4};
    vecs[12] = '{32'hFE000EE3, 32'h0,    32'hFFFFFFFC, 3'd3, 32'hFFFFFFFC};
    vecs[13] = '{32'h800002B7, 32'h0,    32'h80000000, 3'd4, 32'h80000000};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, 32'hFFF00093, 32'h0);
    step(); step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_imm", 64'(out_imm), 64'd0);
    chk("rst_out_fmt", 64'(out_fmt), 64'd0);
    chk("rst_out_target", 64'(out_target), 64'd0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Back-to-back table: each vector appears one cycle after acceptance.
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].pc);
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].instr, vecs[i].pc);
      chk($sformatf("vec%0d_imm", i), 64'(out_imm), 64'(vecs[i].imm));
      chk($sformatf("vec%0d_fmt", i), 64'(out_fmt), 64'(vecs[i].fmt));
      chk($sformatf("vec%0d_target", i), 64'(out_target), 64'(vecs[i].target));
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("drain_empty", 64'(out_valid), 64'd0);

    // Backpressure: A, B buffered, C held upstream, then in-order drain.
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 32'h300);
    step();
    chk_out("bp_a", 32'h00100093, 32'h300);
    drive(1'b1, 32'h00200093, 32'h304);
    step();
    chk("bp_full_in_ready", 64'(in_ready), 64'd0);
    chk_out("bp_a_held", 32'h00100093, 32'h300);
    drive(1'b1, 32'h00300093, 32'h308);
    step(); step();
    chk("bp_still_full", 64'(in_ready), 64'd0);
    chk_out("bp_a_stable", 32'h00100093, 32'h300);
    chk("bp_a_imm_stable", 64'(out_imm), 64'd1);
    out_ready = 1'b1;
    step();
    chk_out("bp_b", 32'h00200093, 32'h304);
    chk("bp_b_imm", 64'(out_imm), 64'd2);
    chk("bp_reopen_in_ready", 64'(in_ready), 64'd1);
    step();
    chk_out("bp_c", 32'h00300093, 32'h308);
    chk("bp_c_imm", 64'(out_imm), 64'd3);
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("bp_done_empty", 64'(out_valid), 64'd0);

    // Flush while full with a new input offered in the same cycle.
    out_ready = 1'b0;
    drive(1'b1, 32'h00A00093, 32'h400);
    step();
    drive(1'b1, 32'h00B00093, 32'h404);
    step();
    chk("fl_full", 64'(in_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, 32'h00D00093, 32'h408);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step();
    chk("fl_no_ghost", 64'(out_valid), 64'd0);
    drive(1'b1, 32'h00E00093, 32'h40C);
    step();
    chk_out("fl_next", 32'h00E00093, 32'h40C);
    chk("fl_next_imm", 64'(out_imm), 64'd14);
    drive(1'b0, 32'h0, 32'h0);
    step();

    // Reset while full: everything zeroed and nothing emerges afterwards.
    out_ready = 1'b0;
    drive(1'b1, 32'h00F00093, 32'h500);
    step();
    drive(1'b1, 32'h01000093, 32'h504);
    step();
    chk("rs_full", 64'(in_ready), 64'd0);
    rst = 1'b1;
    drive(1'b1, 32'h01100093, 32'h508);
    step();
    chk("rs_out_valid", 64'(out_valid), 64'd0);
    chk("rs_in_ready_low", 64'(in_ready), 64'd0);
    chk("rs_instr_zero", 64'(out_instr), 64'd0);
    chk("rs_pc_zero", 64'(out_pc), 64'd0);
    chk("rs_imm_zero", 64'(out_imm), 64'd0);
    chk("rs_target_zero", 64'(out_target), 64'd0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    #1;
    chk("rs_in_ready_high", 64'(in_ready), 64'd1);
    step();
    chk("rs_no_ghost", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, parametrised immediate generator for the decode stage. Supersedes the purely combinational immediate decode.
- Accepts one instruction and PC per handshake. Produces the XLEN-wide sign-extended immediate, a format code and the precomputed PC-relative target (pc+imm).
- Output is held in a 2-entry skid buffer with valid/ready handshakes on both sides, plus a flush input for pipeline redirects.

Parameters:
- XLEN, 32, datapath width (32 or 64); immediates sign-extended to XLEN.
- FMT_W, 3, width of format code.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  drop all buffered entries; input in same cycle not accepted.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  block can accept this cycle.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_instr  out  32  instruction passthrough.
- out_pc  out  XLEN  PC passthrough.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  FMT_W  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm).
- out_target  out  XLEN  out_pc+out_imm, modulo 2^XLEN, computed for every entry.

Behaviour:
- Clocking and reset: single clock; rst is synchronous and active-high. During rst all registers clear: out_valid=0, out_instr/out_pc/out_imm/out_target=0, out_fmt=0. in_ready=0 while rst is high, 1 on the first cycle after.
- Opcode to format mapping:
  - ALUI 0010011, LOAD 0000011, JALR 1100111, SYSTEM 1110011 -> I: {sext instr[31:20]}.
  - STORE 0100011 -> S: {sext instr[31:25],instr[11:7]}.
  - BRANCH 1100011 -> B: {sext instr[31],instr[7],instr[30:25],instr[11:8],0}.
  - LUI 0110111, AUIPC 0010111 -> U: {instr[31:12],12'b0}, bit 31 sign-extended when XLEN=64.
  - JAL 1101111 -> J: {sext instr[31],instr[19:12],instr[20],instr[30:21],0}.
  - Any other opcode -> NONE, imm=0.
- Latency: exactly 1 cycle from accepted input to out_valid with no backpressure. Throughput 1 per cycle.
- Buffer states:
  - EMPTY: out_valid=0.
  - ONE: output register valid.
  - TWO: output register and skid register both valid.
- State transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept + out_ready -> ONE, new data.
  - ONE + accept + !out_ready -> TWO, input goes to skid.
  - ONE + !accept + out_ready -> EMPTY.
  - TWO + out_ready -> ONE, skid moves to output.
  - TWO + !out_ready -> hold.
- Handshake rules:
  - accept = in_valid & in_ready & !flush.
  - in_ready = !rst & (state != TWO); driven from a register, with no combinational path from out_ready.
  - Output fields are stable while out_valid=1 and out_ready=0.
- flush: next state EMPTY regardless of out_ready or in_valid. An output handshake completing in the flush cycle still counts as consumed.
- Reset mid-operation: buffered entries are discarded, no output handshake occurs afterwards, and state returns to EMPTY.
- out_target wraps modulo 2^XLEN, e.g. pc 0x0 + imm -4 = all-ones-minus-3.

Optional Feature:
- Macro IMM_GEN_CSR_ZIMM_EN.
- Defined: SYSTEM opcode with funct3[2]=1 (CSRRWI/CSRRSI/CSRRCI) yields fmt Z and imm = zero-extended instr[19:15]. Other SYSTEM encodings stay I.
- Undefined: all SYSTEM encodings are I-type and fmt Z is never produced.

Test Plan:
- Reset then in_instr=0xFFF00093 (addi -1), pc=0x0, out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, fmt=1, target=0xFFFFFFFF.
- 0x0020A423 (sw 8) -> imm=0x8, fmt=2. Then 0xFE000EE3 (beq -4), pc=0x100 -> imm=0xFFFFFFFC, fmt=3, target=0xFC.
- 0x123452B7 (lui) -> imm=0x12345000, fmt=4. Then 0x0010006F (jal +2048), pc=0x1000 -> imm=0x800, fmt=5, target=0x1800. With XLEN=64, 0x800002B7 -> imm=0xFFFFFFFF80000000.
- Backpressure: out_ready=0, send 3 back-to-back instructions -> first two buffered, in_ready=0 on cycle 3 and the third is held upstream. Raise out_ready -> outputs drain in order with no loss or duplication.
- Flush in state TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed-cycle input never appears at the output. rst asserted in state TWO gives the same result, with all outputs zeroed.
- 0x300FD073 (csrrwi zimm 31) -> with the macro: imm=0x1F, fmt=6. Without the macro: imm=0x300, fmt=1.
